fp_mult_param: RTL and testbench

//   Parametrised multi-cycle IEEE-754-style binary floating-point multiplier. Next generation of f32_mult.

---
 rtl/fp_mult_param.sv | 198 +++++++++++++++++++
 tb/tb_fp_mult_param.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_param.sv
// Parametrised multi-cycle floating-point multiplier: shift-add significand product,
// four rounding modes, DAZ/FTZ, IEEE exception flags and a start/busy/done handshake.
module fp_mult_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [1:0]             rnd_mode,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   p,
    output logic [3:0]             flags
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EXP_S  = EXP_W + 2;
    localparam int CNT_W  = $clog2(MAN_W + 1);
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX   = (1 << EXP_W) - 1;

    localparam logic [1:0] SP_NONE = 2'd0, SP_NAN = 2'd1, SP_INF = 2'd2, SP_ZERO = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;
    state_t state_reg, state_next;

    logic [W-1:0]      a_reg, b_reg, p_reg;
    logic [1:0]        rnd_reg, spec_reg;
    logic              sign_reg, nv_reg, g_reg, rs_reg;
    logic [EXP_S-1:0]  exp_reg;
    logic [SIG_W-1:0]  mcand_reg, mplier_reg;
    logic [PROD_W-1:0] acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [MAN_W-1:0]  mant_reg;
    logic [3:0]        flags_reg;

    // Operand classification (subnormals read as zero)
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inf_times_zero;
    logic [1:0]       spec_next;
    logic [EXP_S-1:0] exp_sum;

    assign ea = a_reg[W-2:MAN_W];
    assign eb = b_reg[W-2:MAN_W];
    assign ma = a_reg[MAN_W-1:0];
    assign mb = b_reg[MAN_W-1:0];
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_inf  = (&ea) & ~|ma;
    assign b_inf  = (&eb) & ~|mb;
    assign a_nan  = (&ea) & |ma;
    assign b_nan  = (&eb) & |mb;
    assign a_snan = a_nan & ~ma[MAN_W-1];
    assign b_snan = b_nan & ~mb[MAN_W-1];
    assign inf_times_zero = (a_inf & b_zero) | (b_inf & a_zero);
    assign exp_sum = {2'b00, ea} + {2'b00, eb} - EXP_S'(BIAS);

    always_comb begin
        spec_next = SP_NONE;
        if (a_nan | b_nan | inf_times_zero) spec_next = SP_NAN;
        else if (a_inf | b_inf)             spec_next = SP_INF;
        else if (a_zero | b_zero)           spec_next = SP_ZERO;
    end

    // One multiplier bit per cycle, MSB first
    logic [PROD_W-1:0] acc_step;
    assign acc_step = {acc_reg[PROD_W-2:0], 1'b0}
                    + (mplier_reg[SIG_W-1] ? {{SIG_W{1'b0}}, mcand_reg} : {PROD_W{1'b0}});

    // Normalisation: product of two 1.x significands lies in [1,4)
    logic              prod_msb;
    logic [MAN_W-1:0]  mant_norm;
    logic              g_norm, rs_norm;
    assign prod_msb  = acc_reg[PROD_W-1];
    assign mant_norm = prod_msb ? acc_reg[2*MAN_W:MAN_W+1] : acc_reg[2*MAN_W-1:MAN_W];
    assign g_norm    = prod_msb ? acc_reg[MAN_W] : acc_reg[MAN_W-1];
    assign rs_norm   = prod_msb ? |acc_reg[MAN_W-1:0] : |acc_reg[MAN_W-2:0];

    // Rounding and final packing
    logic              inexact, inc, carry, to_inf, underflow;
    logic [MAN_W-1:0]  mant_rnd;
    logic [EXP_S-1:0]  exp_rnd;
    logic [W-1:0]      p_next;
    logic [3:0]        flags_next;

    assign inexact   = g_reg | rs_reg;
    assign {carry, mant_rnd} = {1'b0, mant_reg} + {{MAN_W{1'b0}}, inc};
    assign exp_rnd   = exp_reg + {{(EXP_S-1){1'b0}}, carry};
    assign underflow = exp_reg[EXP_S-1] | (exp_reg == '0);
    assign to_inf    = (rnd_reg == 2'b00) | ((rnd_reg == 2'b10) & ~sign_reg)
                     | ((rnd_reg == 2'b11) & sign_reg);

    always_comb begin
        unique case (rnd_reg)
            2'b00:   inc = g_reg & (rs_reg | mant_reg[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = inexact & ~sign_reg;
            default: inc = inexact & sign_reg;
        endcase
    end

    always_comb begin
        p_next     = {sign_reg, exp_rnd[EXP_W-1:0], mant_rnd};
        flags_next = {3'b000, inexact};
        if (spec_reg == SP_NAN) begin
            p_next     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags_next = {nv_reg, 3'b000};
        end else if (spec_reg == SP_INF) begin
            p_next     = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_next = 4'b0000;
        end else if (spec_reg == SP_ZERO) begin
            p_next     = {sign_reg, {(W-1){1'b0}}};
            flags_next = 4'b0000;
        end else if (underflow) begin
            p_next     = {sign_reg, {(W-1){1'b0}}};
            flags_next = 4'b0011;
        end else if (exp_rnd >= EXP_S'(EMAX)) begin
            p_next     = to_inf ? {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                : {sign_reg, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            flags_next = 4'b0101;
        end
    end

    // FSM: state register / next state / outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:   if (start) state_next = S_UNPACK;
            S_UNPACK: state_next = S_MUL;
            S_MUL:    if (cnt_reg == '0) state_next = S_NORM;
            S_NORM:   state_next = S_ROUND;
            S_ROUND:  state_next = S_DONE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == S_UNPACK) || (state_reg == S_MUL)
            || (state_reg == S_NORM)   || (state_reg == S_ROUND);
        done = (state_reg == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0; b_reg <= '0; rnd_reg <= '0; spec_reg <= '0;
            sign_reg <= 1'b0; nv_reg <= 1'b0; g_reg <= 1'b0; rs_reg <= 1'b0;
            exp_reg <= '0; mcand_reg <= '0; mplier_reg <= '0; acc_reg <= '0;
            cnt_reg <= '0; mant_reg <= '0; p_reg <= '0; flags_reg <= '0;
        end else begin
            unique case (state_reg)
                S_IDLE: if (start) begin
                    a_reg   <= a;
                    b_reg   <= b;
                    rnd_reg <= rnd_mode;
                end
                S_UNPACK: begin
                    sign_reg   <= a_reg[W-1] ^ b_reg[W-1];
                    exp_reg    <= exp_sum;
                    spec_reg   <= spec_next;
                    nv_reg     <= inf_times_zero | a_snan | b_snan;
                    mcand_reg  <= {1'b1, ma};
                    mplier_reg <= {1'b1, mb};
                    acc_reg    <= '0;
                    cnt_reg    <= CNT_W'(MAN_W);
                end
                S_MUL: begin
                    acc_reg    <= acc_step;
                    mplier_reg <= {mplier_reg[SIG_W-2:0], 1'b0};
                    cnt_reg    <= cnt_reg - CNT_W'(1);
                end
                S_NORM: begin
                    exp_reg  <= exp_reg + {{(EXP_S-1){1'b0}}, prod_msb};
                    mant_reg <= mant_norm;
                    g_reg    <= g_norm;
                    rs_reg   <= rs_norm;
                end
                S_ROUND: begin
                    p_reg     <= p_next;
                    flags_reg <= flags_next;
                end
                default: ;
            endcase
        end
    end

    assign p     = p_reg;
    assign flags = flags_reg;
endmodule

// File: tb/tb_fp_mult_param.sv
// Randomised bench for fp_mult_param (default and 5/10 instances) against an
// arithmetic reference model; a single negedge monitor checks every cycle.
module tb_fp_mult_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a0, b0, p0;
    logic [15:0] a1, b1, p1;
    logic [1:0]  m0, m1;
    logic        start0, start1, busy0, busy1, done0, done1;
    logic [3:0]  flags0, flags1;

    fp_mult_param #(.EXP_W(8), .MAN_W(23)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .rnd_mode(m0), .start(start0),
        .busy(busy0), .done(done0), .p(p0), .flags(flags0));
    fp_mult_param #(.EXP_W(5), .MAN_W(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .rnd_mode(m1), .start(start1),
        .busy(busy1), .done(done1), .p(p1), .flags(flags1));

    typedef struct {
        logic [31:0] a, b;
        logic [1:0]  m;
        logic [31:0] p;
        logic [3:0]  f;
        int          due;
    } txn_t;
    txn_t q[2][$];

    typedef struct packed {
        logic [31:0] a, b;
        logic [1:0]  m;
        logic [31:0] p;
        logic [3:0]  f;
    } vec_t;
    vec_t vecs[16] = '{
        '{32'h3F800000, 32'h40000000, 2'd0, 32'h40000000, 4'b0000},
        '{32'hC0400000, 32'h40000000, 2'd0, 32'hC0C00000, 4'b0000},
        '{32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001},
        '{32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'b0001},
        '{32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0001},
        '{32'h3F800001, 32'h3F800001, 2'd3, 32'h3F800002, 4'b0001},
        '{32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101},
        '{32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101},
        '{32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'b0101},
        '{32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'b1000},
        '{32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b1000},
        '{32'h7FC00000, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b0000},
        '{32'hFF800000, 32'h3F800000, 2'd0, 32'hFF800000, 4'b0000},
        '{32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 4'b0011},
        '{32'h00000001, 32'h3F800000, 2'd0, 32'h00000000, 4'b0000},
        '{32'h3FC00000, 32'h3FC00000, 2'd0, 32'h40100000, 4'b0000}
    };

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h cyc=%0d", nm, got, want, cyc);
        end
    endtask

    // Exact integer product, then round by comparing the discarded remainder with one half ulp
    function automatic void model(input int ew, input int mw, input logic [31:0] a,
                                  input logic [31:0] b, input logic [1:0] m,
                                  output logic [31:0] p, output logic [3:0] f);
        longint unsigned emax, mmask, ea, eb, ma, mb, prod, qv, rem, half, sbit, inf_v;
        longint e;
        int sh;
        bit s, za, zb, ia, ib, na, nb, sna, snb, inexact, inc, to_inf;
        emax  = (64'd1 << ew) - 1;
        mmask = (64'd1 << mw) - 1;
        ea = (64'(a) >> mw) & emax;
        eb = (64'(b) >> mw) & emax;
        ma = 64'(a) & mmask;
        mb = 64'(b) & mmask;
        s  = a[ew+mw] ^ b[ew+mw];
        sbit  = 64'(s) << (ew + mw);
        inf_v = sbit | (emax << mw);
        za = (ea == 0);  zb = (eb == 0);
        ia = (ea == emax) && (ma == 0);  ib = (eb == emax) && (mb == 0);
        na = (ea == emax) && (ma != 0);  nb = (eb == emax) && (mb != 0);
        sna = na && (((ma >> (mw - 1)) & 1) == 0);
        snb = nb && (((mb >> (mw - 1)) & 1) == 0);
        f = 4'b0000;
        if (na || nb || (ia && zb) || (ib && za)) begin
            p = 32'((emax << mw) | (64'd1 << (mw - 1)));
            f[3] = (ia && zb) || (ib && za) || sna || snb;
        end else if (ia || ib) begin
            p = 32'(inf_v);
        end else if (za || zb) begin
            p = 32'(sbit);
        end else begin
            prod = (ma | (64'd1 << mw)) * (mb | (64'd1 << mw));
            e  = longint'(ea + eb) - longint'((64'd1 << (ew - 1)) - 1);
            sh = mw;
            if (prod >= (64'd1 << (2 * mw + 1))) begin
                sh = mw + 1;
                e++;
            end
            qv   = prod >> sh;
            rem  = prod - (qv << sh);
            half = 64'd1 << (sh - 1);
            inexact = (rem != 0);
            if (e < 1) begin
                p = 32'(sbit);
                f = 4'b0011;
            end else begin
                case (m)
                    2'd0:    inc = (rem > half) || ((rem == half) && qv[0]);
                    2'd1:    inc = 1'b0;
                    2'd2:    inc = inexact && !s;
                    default: inc = inexact && s;
                endcase
                qv = qv + 64'(inc);
                if (qv == (64'd2 << mw)) begin
                    qv = qv >> 1;
                    e++;
                end
                if (e >= longint'(emax)) begin
                    to_inf = (m == 2'd0) || ((m == 2'd2) && !s) || ((m == 2'd3) && s);
                    p = to_inf ? 32'(inf_v) : 32'(sbit | ((emax - 1) << mw) | mmask);
                    f = 4'b0101;
                end else begin
                    p = 32'(sbit | (64'(e) << mw) | (qv & mmask));
                    f = {3'b000, inexact};
                end
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op(int ew, int mw);
        longint unsigned emax, bias, e, mt;
        int sel;
        emax = (64'd1 << ew) - 1;
        bias = (64'd1 << (ew - 1)) - 1;
        mt   = {$urandom, $urandom} & ((64'd1 << mw) - 1);
        sel  = int'($urandom_range(0, 9));
        case (sel)
            0: begin
                e = ($urandom_range(0, 1) != 0) ? 64'd0 : emax;
                if ($urandom_range(0, 1) != 0) mt = 0;
            end
            1, 2, 3: e = bias + 64'($urandom_range(0, 6)) - 3;
            4, 5: begin
                e  = bias + 64'($urandom_range(0, 6)) - 3;
                mt = mt & ~((64'd1 << (mw - 3)) - 1);
            end
            default: e = 64'($urandom_range(1, 32'(emax - 1)));
        endcase
        return 32'((64'($urandom_range(0, 1)) << (ew + mw)) | (e << mw) | mt);
    endfunction

    // Issue one operation; optionally pulse a stray start inj negedges later
    task automatic run(int id, logic [31:0] a, logic [31:0] b, logic [1:0] m, int inj, bit wait_done);
        txn_t t;
        @(negedge clk);
        if (id == 0) begin a0 = a; b0 = b; m0 = m; start0 = 1'b1; end
        else begin a1 = a[15:0]; b1 = b[15:0]; m1 = m; start1 = 1'b1; end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        t.a = a; t.b = b; t.m = m;
        model((id == 0) ? 8 : 5, (id == 0) ? 23 : 10, a, b, m, t.p, t.f);
        t.due = cyc + ((id == 0) ? 27 : 14);
        q[id].push_back(t);
        if (inj > 0) begin
            repeat (inj) @(negedge clk);
            a0 = $urandom; b0 = $urandom; m0 = 2'($urandom_range(0, 3)); start0 = 1'b1;
            @(posedge clk);
            #1;
            start0 = 1'b0;
        end
        if (wait_done) begin
            for (int k = 0; k < 200 && q[id].size() != 0; k++) begin
                @(negedge clk);
                #1;
            end
            if (q[id].size() != 0) begin
                checks++;
                failures++;
                $display("FAIL wait_done dut%0d a=%h b=%h no result", id, a, b);
                q[id].delete();
            end
        end
    endtask

    task automatic mon(int id, logic dn, logic [31:0] pv, logic [3:0] fv, logic bz);
        txn_t t;
        if (q[id].size() == 0) begin
            chk($sformatf("idle_done dut%0d", id), 32'(dn), 32'd0);
            chk($sformatf("idle_busy dut%0d", id), 32'(bz), 32'd0);
        end else begin
            t = q[id][0];
            if (dn) begin
                chk($sformatf("latency dut%0d", id), 32'(cyc), 32'(t.due));
                chk($sformatf("p dut%0d a=%h b=%h m=%0d", id, t.a, t.b, t.m), pv, t.p);
                chk($sformatf("flags dut%0d a=%h b=%h m=%0d", id, t.a, t.b, t.m), 32'(fv), 32'(t.f));
                chk($sformatf("busy_at_done dut%0d", id), 32'(bz), 32'd0);
                $display("txn dut%0d a=%h b=%h m=%0d p=%h flags=%b cyc=%0d", id, t.a, t.b, t.m, pv, fv, cyc);
                void'(q[id].pop_front());
            end else if (cyc >= t.due) begin
                checks++;
                failures++;
                $display("FAIL timeout dut%0d a=%h b=%h got=no_done want=done_at_%0d", id, t.a, t.b, t.due);
                void'(q[id].pop_front());
            end else begin
                chk($sformatf("busy dut%0d", id), 32'(bz), 32'd1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, done0, p0, flags0, busy0);
            mon(1, done1, {16'h0000, p1}, flags1, busy1);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] mp;
        logic [3:0]  mf;
        a0 = '0; b0 = '0; m0 = '0; start0 = 1'b0;
        a1 = '0; b1 = '0; m1 = '0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_p0", p0, 32'd0);
        chk("reset_flags0", 32'(flags0), 32'd0);
        chk("reset_done0", 32'(done0), 32'd0);
        chk("reset_busy0", 32'(busy0), 32'd0);
        chk("reset_p1", 32'(p1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            model(8, 23, vecs[i].a, vecs[i].b, vecs[i].m, mp, mf);
            chk($sformatf("model_p vec%0d", i), mp, vecs[i].p);
            chk($sformatf("model_f vec%0d", i), 32'(mf), 32'(vecs[i].f));
            run(0, vecs[i].a, vecs[i].b, vecs[i].m, 0, 1'b1);
        end

        model(5, 10, 32'h3C00, 32'h4000, 2'd0, mp, mf);
        chk("model_p half", mp, 32'h4000);
        chk("model_f half", 32'(mf), 32'd0);
        run(1, 32'h3C00, 32'h4000, 2'd0, 0, 1'b1);

        run(0, 32'h3F800001, 32'h3F800001, 2'd2, 8, 1'b1);
        run(0, 32'h3F800001, 32'h3F800001, 2'd0, 28, 1'b1);
        repeat (40) @(negedge clk);

        run(0, 32'h40400000, 32'h40400000, 2'd0, 0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        q[0].delete();
        q[1].delete();
        #1;
        chk("abort_p", p0, 32'd0);
        chk("abort_flags", 32'(flags0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 80; i++)
            run(0, rnd_op(8, 23), rnd_op(8, 23), 2'($urandom_range(0, 3)), 0, 1'b1);
        for (int i = 0; i < 25; i++)
            run(1, rnd_op(5, 10), rnd_op(5, 10), 2'($urandom_range(0, 3)), 0, 1'b1);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
